uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter: DEPTH, 16, number of storage entries; power of two, 2..256.
REQ-002 Parameter: ADDR_W, 4, log2(DEPTH).
REQ-003 Parameter: TIMEOUT_CLKS, 20833, idle clocks before timeout_irq; 1..65535.
REQ-004 Port: clk  input  1  single rising-edge clock for all logic.
REQ-005 Port: reset  input  1  synchronous, active-low reset, sampled on clk rising edge.
REQ-006 Port: wr_data  input  8  received byte from the UART receiver.
REQ-007 Port: wr_done  input  1  one-cycle strobe; wr_data/wr_error valid this cycle.
REQ-008 Port: wr_error  input  1  stop-bit error flag accompanying wr_data.
REQ-009 Port: rd_data  output  8  head-entry byte.
REQ-010 Port: rd_err  output  1  head-entry error tag.
REQ-011 Port: rd_valid  output  1  head entry present (not empty).
REQ-012 Port: rd_ready  input  1  consumer accepts head when rd_valid&rd_ready.
REQ-013 Port: count  output  ADDR_W+1  current occupancy, 0..DEPTH.
REQ-014 Port: full  output  1  count==DEPTH.
REQ-015 Port: overrun  output  1  sticky: a byte was lost.
REQ-016 Port: clr_overrun  input  1  clears overrun.
REQ-017 Port: thresh  input  ADDR_W+1  level-interrupt threshold.
REQ-018 Port: level_irq  output  1  occupancy reached thresh.
REQ-019 Port: timeout_irq  output  1  data stale in FIFO.

Function
REQ-020 Write = wr_done & accepted; entry {wr_error, wr_data} stored at wr_ptr, wr_ptr increments mod DEPTH.
REQ-021 Read = rd_valid & rd_ready; rd_ptr increments mod DEPTH; a read when empty has no effect.
REQ-022 rd_data/rd_err combinationally reflect entry at rd_ptr; rd_valid = (count!=0); no fall-through: byte written at edge N first visible after edge N.
REQ-023 count: +1 on write only, -1 on read only, unchanged on simultaneous read and write.
REQ-024 wr_done while full: accepted if a read occurs the same cycle, else byte dropped, FIFO unchanged, overrun set.
REQ-025 Write while empty plus rd_ready: no read that cycle; count becomes 1.
REQ-026 overrun held until clr_overrun=1; overrun-set and clr_overrun in same cycle: set wins.
REQ-027 level_irq registered: 1 when thresh!=0 and next-cycle count>=thresh; thresh==0 keeps it 0.
REQ-028 Idle counter: reset to 0 on any write or read or when empty; else increments, saturating at TIMEOUT_CLKS.
REQ-029 timeout_irq = (idle counter==TIMEOUT_CLKS) & rd_valid; clears the cycle after any read or write.
REQ-030 Pointers wrap mod DEPTH; full/empty derived from count, never from pointer equality alone.

Reset
REQ-031 On reset=0 at a clk edge: wr_ptr, rd_ptr, count, idle counter =0; overrun, level_irq, timeout_irq =0; rd_valid=0, full=0.
REQ-032 Storage contents not reset; rd_data/rd_err undefined while rd_valid=0.
REQ-033 Reset mid-traffic discards all entries; wr_done coincident with reset is ignored.

Configuration
REQ-034 Macro UART_RX_FIFO_ERR_DROP_EN defined: wr_done with wr_error=1 discards byte, no storage, no overrun, no idle-counter reset; rd_err tied 0.
REQ-035 Macro undefined: errored bytes stored normally with rd_err=1.

Verification
REQ-036 Write 0x41,0x42,0x43 (rd_ready=0), then rd_ready=1 -> rd_data 0x41,0x42,0x43 on successive cycles, count 3->0, rd_valid low after.
REQ-037 Write 17 bytes, DEPTH=16, no reads -> full=1 after 16th, 17th dropped, overrun=1; clr_overrun -> overrun=0; reads return bytes 1..16.
REQ-038 FIFO full, wr_done 0x55 with simultaneous read -> no overrun, count stays 16, 0x55 read last.
REQ-039 thresh=4, write 4 bytes -> level_irq=1 after 4th write edge; one read -> level_irq=0.
REQ-040 TIMEOUT_CLKS=8, one byte written, idle -> timeout_irq=1 exactly 8 cycles later; read -> clears next cycle.
REQ-041 wr_error=1 with 0xAA -> without macro rd_err=1, rd_data 0xAA; with UART_RX_FIFO_ERR_DROP_EN count stays 0.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte FIFO for a UART, with an error tag per
// entry, a sticky overrun flag, a level interrupt and an idle-timeout
// interrupt.
// Optional build macro UART_RX_FIFO_ERR_DROP_EN: bytes that arrive with a
// stop-bit error are discarded instead of stored, and rd_err is tied low.
module uart_rx_fifo #(
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4,
    parameter int TIMEOUT_CLKS = 20833
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        wr_data,
    input  logic              wr_done,
    input  logic              wr_error,
    output logic [7:0]        rd_data,
    output logic              rd_err,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              overrun,
    input  logic              clr_overrun,
    input  logic [ADDR_W:0]   thresh,
    output logic              level_irq,
    output logic              timeout_irq
);

    localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W + 1)'(DEPTH);
    localparam logic [15:0]     TIMEOUT_C = 16'(TIMEOUT_CLKS);

    logic [8:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_next;
    logic [15:0]       idle_cnt;
    logic [8:0]        head;
    logic              wr_valid;
    logic              do_read;
    logic              do_write;
    logic              drop;

`ifdef UART_RX_FIFO_ERR_DROP_EN
    // Errored bytes never reach the FIFO logic at all.
    assign wr_valid = wr_done & ~wr_error;
    assign rd_err   = 1'b0;
`else
    assign wr_valid = wr_done;
    assign rd_err   = head[8];
`endif

    // Full/empty come from the occupancy count; pointers alone are ambiguous.
    assign rd_valid = (count != '0);
    assign full     = (count == DEPTH_C);
    assign do_read  = rd_valid & rd_ready;
    // A read in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_write = wr_valid & (~full | do_read);
    assign drop     = wr_valid & full & ~do_read;

    assign head        = mem[rd_ptr];
    assign rd_data     = head[7:0];
    assign timeout_irq = (idle_cnt == TIMEOUT_C) & rd_valid;

    // Occupancy after this edge; feeds both count and the level interrupt.
    always_comb begin
        // NOTE: default first so every path assigns count_next and no latch is inferred.
        count_next = count;
        if (do_write && !do_read)
            count_next = count + 1'b1;
        else if (do_read && !do_write)
            count_next = count - 1'b1;
    end

    // Storage array: written at wr_ptr, never cleared.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; entries are only meaningful once rd_valid says so.
        if (reset && do_write)
            mem[wr_ptr] <= {wr_error, wr_data};
    end

    // Pointers, occupancy and the registered interrupts/flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overrun   <= 1'b0;
            level_irq <= 1'b0;
        end else begin
            if (do_write)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_read)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            // Losing a byte outranks a simultaneous clear.
            if (drop)
                overrun <= 1'b1;
            else if (clr_overrun)
                overrun <= 1'b0;
            level_irq <= (thresh != '0) && (count_next >= thresh);
        end
    end

    // Idle counter: restarts on any traffic or while empty, saturates at the timeout.
    always_ff @(posedge clk) begin
        if (!reset)
            idle_cnt <= '0;
        else if (do_write || do_read || count == '0)
            idle_cnt <= '0;
        else if (idle_cnt != TIMEOUT_C)
            idle_cnt <= idle_cnt + 1'b1;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: a table of directed vectors, a few hand-written
// corner sequences, then randomized traffic against a queue-based model.
module tb_uart_rx_fifo;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int TO     = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        wr_data;
    logic              wr_done;
    logic              wr_error;
    logic [7:0]        rd_data;
    logic              rd_err;
    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              overrun;
    logic              clr_overrun;
    logic [ADDR_W:0]   thresh;
    logic              level_irq;
    logic              timeout_irq;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT_CLKS(TO)) dut (
        .clk(clk), .reset(reset), .wr_data(wr_data), .wr_done(wr_done),
        .wr_error(wr_error), .rd_data(rd_data), .rd_err(rd_err),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .count(count), .full(full),
        .overrun(overrun), .clr_overrun(clr_overrun), .thresh(thresh),
        .level_irq(level_irq), .timeout_irq(timeout_irq)
    );

    typedef struct {
        bit       rst_n;
        bit       wd;
        bit [7:0] d;
        bit       we;
        bit       rr;
        bit       clr;
        bit [4:0] th;
    } in_t;

    typedef struct {
        in_t      in;
        int       e_count;
        bit       e_valid;
        bit       e_full;
        bit       e_ovr;
        bit       e_lvl;
        bit [7:0] e_data;
        bit       e_err;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit [8:0] mq[$];
    bit       m_ovr;
    bit       m_lvl;
    int       m_idle;

`ifdef UART_RX_FIFO_ERR_DROP_EN
    localparam bit DROP_ERR = 1'b1;
`else
    localparam bit DROP_ERR = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic in_t mk(bit rst_n, bit wd, bit [7:0] d, bit we, bit rr, bit clr, bit [4:0] th);
        in_t v;
        v.rst_n = rst_n; v.wd = wd; v.d = d; v.we = we; v.rr = rr; v.clr = clr; v.th = th;
        return v;
    endfunction

    function automatic in_t idle_in(bit [4:0] th);
        return mk(1, 0, 8'h00, 0, 0, 0, th);
    endfunction

    // Model: the FIFO as a bounded queue of {err, byte}.
    task automatic model_update(input in_t v);
        bit rd, wv, wrote, lost, was_empty;
        if (!v.rst_n) begin
            mq.delete();
            m_ovr  = 0;
            m_lvl  = 0;
            m_idle = 0;
            return;
        end
        was_empty = (mq.size() == 0);
        rd        = !was_empty && v.rr;
        wv        = v.wd && !(DROP_ERR && v.we);
        wrote     = 0;
        lost      = 0;
        if (rd) void'(mq.pop_front());
        if (wv) begin
            if (mq.size() < DEPTH) begin
                mq.push_back({v.we, v.d});
                wrote = 1;
            end else begin
                lost = 1;
            end
        end
        if (lost) m_ovr = 1;
        else if (v.clr) m_ovr = 0;
        m_lvl = (v.th != 0) && (mq.size() >= int'(v.th));
        if (rd || wrote || was_empty) m_idle = 0;
        else if (m_idle < TO) m_idle++;
    endtask

    task automatic compare_model();
        bit [8:0] h;
        check("count", 32'(count), 32'(mq.size()));
        check("rd_valid", 32'(rd_valid), 32'(mq.size() != 0));
        check("full", 32'(full), 32'(mq.size() == DEPTH));
        check("overrun", 32'(overrun), 32'(m_ovr));
        check("level_irq", 32'(level_irq), 32'(m_lvl));
        check("timeout_irq", 32'(timeout_irq), 32'(m_idle == TO && mq.size() != 0));
        if (mq.size() != 0) begin
            h = mq[0];
            check("rd_data", 32'(rd_data), 32'(h[7:0]));
            check("rd_err", 32'(rd_err), DROP_ERR ? 32'd0 : 32'(h[8]));
        end
    endtask

    // Apply one cycle of inputs, step the model, sample just after the edge.
    task automatic step(input in_t v);
        reset       = v.rst_n;
        wr_done     = v.wd;
        wr_data     = v.d;
        wr_error    = v.we;
        rd_ready    = v.rr;
        clr_overrun = v.clr;
        thresh      = v.th;
        model_update(v);
        @(posedge clk);
        #1;
        compare_model();
    endtask

    vec_t tbl[$];

    task automatic add(input in_t v, input int c, input bit va, input bit fu, input bit ov,
                       input bit lv, input bit [7:0] dt, input bit er);
        vec_t r;
        r.in = v; r.e_count = c; r.e_valid = va; r.e_full = fu; r.e_ovr = ov;
        r.e_lvl = lv; r.e_data = dt; r.e_err = er;
        tbl.push_back(r);
    endtask

    initial begin
        reset = 1'b0; wr_done = 1'b0; wr_data = '0; wr_error = 1'b0;
        rd_ready = 1'b0; clr_overrun = 1'b0; thresh = '0;

        // ---------------- directed table ----------------
        add(mk(0,0,8'h00,0,0,0,0), 0,0,0,0,0,8'h00,0);
        add(mk(1,1,8'h41,0,0,0,0), 1,1,0,0,0,8'h41,0);
        add(mk(1,1,8'h42,0,0,0,0), 2,1,0,0,0,8'h41,0);
        add(mk(1,1,8'h43,0,0,0,0), 3,1,0,0,0,8'h41,0);
        add(mk(1,0,8'h00,0,1,0,0), 2,1,0,0,0,8'h42,0);
        add(mk(1,0,8'h00,0,1,0,0), 1,1,0,0,0,8'h43,0);
        add(mk(1,0,8'h00,0,1,0,0), 0,0,0,0,0,8'h00,0);
        add(mk(1,1,8'h44,0,1,0,0), 1,1,0,0,0,8'h44,0);   // write into empty with rd_ready
        add(mk(1,0,8'h00,0,1,0,0), 0,0,0,0,0,8'h00,0);
        add(mk(1,1,8'h01,0,0,0,4), 1,1,0,0,0,8'h01,0);
        add(mk(1,1,8'h02,0,0,0,4), 2,1,0,0,0,8'h01,0);
        add(mk(1,1,8'h03,0,0,0,4), 3,1,0,0,0,8'h01,0);
        add(mk(1,1,8'h04,0,0,0,4), 4,1,0,0,1,8'h01,0);
        add(mk(1,0,8'h00,0,1,0,4), 3,1,0,0,0,8'h02,0);
        add(mk(0,0,8'h00,0,0,0,0), 0,0,0,0,0,8'h00,0);
        if (DROP_ERR) add(mk(1,1,8'hAA,1,0,0,0), 0,0,0,0,0,8'h00,0);
        else          add(mk(1,1,8'hAA,1,0,0,0), 1,1,0,0,0,8'hAA,1);
        add(mk(0,0,8'h00,0,0,0,0), 0,0,0,0,0,8'h00,0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].in);
            check($sformatf("tbl%0d.count", i), 32'(count), 32'(tbl[i].e_count));
            check($sformatf("tbl%0d.valid", i), 32'(rd_valid), 32'(tbl[i].e_valid));
            check($sformatf("tbl%0d.full", i), 32'(full), 32'(tbl[i].e_full));
            check($sformatf("tbl%0d.ovr", i), 32'(overrun), 32'(tbl[i].e_ovr));
            check($sformatf("tbl%0d.lvl", i), 32'(level_irq), 32'(tbl[i].e_lvl));
            if (tbl[i].e_valid) begin
                check($sformatf("tbl%0d.data", i), 32'(rd_data), 32'(tbl[i].e_data));
                check($sformatf("tbl%0d.err", i), 32'(rd_err), 32'(tbl[i].e_err));
            end
        end

        // ---------------- 17 writes into a 16-deep FIFO ----------------
        for (int i = 1; i <= 17; i++) begin
            step(mk(1,1,8'(i),0,0,0,0));
            if (i == 16) check("fill16.full", 32'(full), 32'd1);
        end
        check("fill17.count", 32'(count), 32'd16);
        check("fill17.overrun", 32'(overrun), 32'd1);
        step(mk(1,0,8'h00,0,0,1,0));
        check("clr.overrun", 32'(overrun), 32'd0);
        for (int i = 1; i <= 16; i++) begin
            check($sformatf("drain%0d.data", i), 32'(rd_data), 32'(i));
            step(mk(1,0,8'h00,0,1,0,0));
        end
        check("drain.valid", 32'(rd_valid), 32'd0);

        // ---------------- full + write + read together ----------------
        for (int i = 0; i < 16; i++) step(mk(1,1,8'(8'h10 + i),0,0,0,0));
        step(mk(1,1,8'h55,0,1,0,0));
        check("fullrw.count", 32'(count), 32'd16);
        check("fullrw.overrun", 32'(overrun), 32'd0);
        for (int i = 0; i < 15; i++) step(mk(1,0,8'h00,0,1,0,0));
        check("fullrw.last", 32'(rd_data), 32'h55);
        step(mk(1,0,8'h00,0,1,0,0));

        // ---------------- overrun set and clear in the same cycle ----------------
        for (int i = 0; i < 16; i++) step(mk(1,1,8'(i),0,0,0,0));
        step(mk(1,1,8'hEE,0,0,1,0));
        check("setclr.overrun", 32'(overrun), 32'd1);

        // ---------------- reset mid-traffic with coincident wr_done ----------------
        step(mk(0,1,8'h77,0,1,0,0));
        check("rstmid.count", 32'(count), 32'd0);
        check("rstmid.overrun", 32'(overrun), 32'd0);
        step(idle_in(0));
        check("rstmid.valid", 32'(rd_valid), 32'd0);

        // ---------------- idle timeout ----------------
        step(mk(1,1,8'hC1,0,0,0,0));
        step(mk(1,1,8'hC2,0,0,0,0));
        for (int i = 1; i <= TO; i++) begin
            step(idle_in(0));
            if (i == TO - 1) check("to.early", 32'(timeout_irq), 32'd0);
        end
        check("to.fire", 32'(timeout_irq), 32'd1);
        step(idle_in(0));
        check("to.hold", 32'(timeout_irq), 32'd1);
        step(mk(1,0,8'h00,0,1,0,0));
        check("to.clear", 32'(timeout_irq), 32'd0);
        check("to.valid", 32'(rd_valid), 32'd1);

        // ---------------- randomized traffic against the model ----------------
        for (int cyc = 0; cyc < 3000; cyc++) begin
            in_t v;
            int  rbias;
            rbias   = ((cyc / 250) % 2 == 1) ? 80 : 30;
            v.rst_n = ($urandom_range(0, 299) != 0);
            v.wd    = ($urandom_range(0, 99) < 50);
            v.d     = 8'($urandom);
            v.we    = ($urandom_range(0, 9) == 0);
            v.rr    = ($urandom_range(0, 99) < rbias);
            v.clr   = ($urandom_range(0, 19) == 0);
            v.th    = 5'($urandom_range(0, 17));
            if ((cyc / 100) % 7 == 3) begin
                v.wd = 0;
                v.rr = 0;
            end
            step(v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
